// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_op_sequencer_if                                        |
// | Description : Request, external-ALU and response bundle of the sequencer |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface alu_op_sequencer_if #(
   parameter int SIZE = 10
);
   logic            req_valid;
   logic            req_ready;
   logic [2:0]      req_op;
   logic [SIZE:0]   req_a;
   logic [SIZE:0]   req_b;
   logic [3:0]      req_shamt;

   logic [2:0]      alu_ctl;
   logic [SIZE:0]   alu_in1;
   logic [SIZE:0]   alu_in2;
   logic [SIZE:0]   alu_out;
   logic            alu_zero;

   logic            rsp_valid;
   logic            rsp_ready;
   logic [SIZE:0]   rsp_result;
   logic            rsp_zero;

   logic            busy;

   // The sequencer itself.
   modport master (
      input  req_valid, req_op, req_a, req_b, req_shamt,
      input  alu_out, alu_zero,
      input  rsp_ready,
      output req_ready,
      output alu_ctl, alu_in1, alu_in2,
      output rsp_valid, rsp_result, rsp_zero,
      output busy
   );

   // Requester, ALU and response consumer.
   modport slave (
      output req_valid, req_op, req_a, req_b, req_shamt,
      output alu_out, alu_zero,
      output rsp_ready,
      input  req_ready,
      input  alu_ctl, alu_in1, alu_in2,
      input  rsp_valid, rsp_result, rsp_zero,
      input  busy
   );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_op_sequencer                                           |
// | Description : Runs one request at a time through an external            |
// |               combinational ALU and holds the result until taken.       |
// |               Define ALU_SEQ_MULTISHIFT_EN for multi-pass shifts.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module alu_op_sequencer #(
   parameter int SIZE = 10
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   alu_op_sequencer_if.master bus
);

   localparam logic [2:0] c_op_null  = 3'b111;
`ifdef ALU_SEQ_MULTISHIFT_EN
   localparam logic [2:0] c_op_pass  = 3'b000;
   localparam logic [2:0] c_op_shl   = 3'b100;
   localparam logic [2:0] c_op_shr   = 3'b110;
`endif

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_exec  = 2'd1;
`ifdef ALU_SEQ_MULTISHIFT_EN
   localparam logic [1:0] c_st_shift = 2'd2;
`endif
   localparam logic [1:0] c_st_hold  = 2'd3;

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [2:0]    r_op;
   logic [SIZE:0] r_a;
   logic [SIZE:0] r_b;
   logic [SIZE:0] r_result;
   logic          r_zero;
   logic          w_accept;
   logic [2:0]    w_op_eff;
`ifdef ALU_SEQ_MULTISHIFT_EN
   logic [3:0]    r_cnt;
   logic [SIZE:0] r_acc;
   logic          w_is_shift;
   logic          w_multi;
`else
   logic          w_unused_shamt;
`endif

   assign w_accept = bus.req_valid && (r_state == c_st_idle);

`ifdef ALU_SEQ_MULTISHIFT_EN
   assign w_is_shift = (bus.req_op == c_op_shl) || (bus.req_op == c_op_shr);
   assign w_multi    = w_is_shift && (bus.req_shamt != 4'd0);
   // A zero-count shift degenerates to a single pass-through of operand a.
   assign w_op_eff   = (w_is_shift && !w_multi) ? c_op_pass : bus.req_op;
`else
   assign w_op_eff       = bus.req_op;
   assign w_unused_shamt = ^bus.req_shamt;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: begin
            if (w_accept) begin
`ifdef ALU_SEQ_MULTISHIFT_EN
               w_state_nxt = w_multi ? c_st_shift : c_st_exec;
`else
               w_state_nxt = c_st_exec;
`endif
            end
         end
         c_st_exec: begin
            w_state_nxt = c_st_hold;
         end
`ifdef ALU_SEQ_MULTISHIFT_EN
         c_st_shift: begin
            if (r_cnt == 4'd1) begin
               w_state_nxt = c_st_hold;
            end
         end
`endif
         c_st_hold: begin
            if (bus.rsp_ready) begin
               w_state_nxt = c_st_idle;
            end
         end
         default: begin
            w_state_nxt = c_st_idle;
         end
      endcase
   end

   always_comb begin
      bus.alu_ctl = c_op_null;
      bus.alu_in1 = '0;
      bus.alu_in2 = '0;
      case (r_state)
         c_st_exec: begin
            bus.alu_ctl = r_op;
            bus.alu_in1 = r_a;
            bus.alu_in2 = r_b;
         end
`ifdef ALU_SEQ_MULTISHIFT_EN
         c_st_shift: begin
            bus.alu_ctl = r_op;
            bus.alu_in1 = r_acc;
         end
`endif
         default: begin
         end
      endcase
   end

   assign bus.req_ready  = (r_state == c_st_idle);
   assign bus.busy       = (r_state != c_st_idle);
   assign bus.rsp_valid  = (r_state == c_st_hold);
   assign bus.rsp_result = r_result;
   assign bus.rsp_zero   = r_zero;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_zero   <= 1'b0;
`ifdef ALU_SEQ_MULTISHIFT_EN
         r_cnt    <= '0;
         r_acc    <= '0;
`endif
      end else begin
         if (w_accept) begin
            r_op <= w_op_eff;
            r_a  <= bus.req_a;
            r_b  <= bus.req_b;
`ifdef ALU_SEQ_MULTISHIFT_EN
            // The accumulator starts at a so every shift pass reads the same source.
            r_cnt <= w_multi ? bus.req_shamt : 4'd0;
            r_acc <= bus.req_a;
`endif
         end
         if (r_state == c_st_exec) begin
            if (r_op == c_op_null) begin
               r_result <= '0;
               r_zero   <= 1'b1;
            end else begin
               r_result <= bus.alu_out;
               r_zero   <= bus.alu_zero;
            end
         end
`ifdef ALU_SEQ_MULTISHIFT_EN
         if (r_state == c_st_shift) begin
            r_acc <= bus.alu_out;
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               r_result <= bus.alu_out;
               r_zero   <= bus.alu_zero;
            end
         end
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_alu_op_sequencer                                        |
// | Description : Directed scoreboard bench with a behavioural ALU           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_alu_op_sequencer;
   localparam int SIZE = 10;

   typedef struct {
      logic [SIZE:0] res;
      logic          zero;
      int            lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc      = 0;
   int   acc_edge = 0;
   int   n_checks = 0;
   int   n_err    = 0;
   exp_t q[$];
   exp_t cur;
   bit   have_cur   = 1'b0;
   logic prev_valid = 1'b0;
   bit   mon_en     = 1'b1;

   alu_op_sequencer_if #(.SIZE(SIZE)) bus ();

   alu_op_sequencer #(.SIZE(SIZE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) acc_edge <= cyc + 1;
   end

   // Behavioural external ALU.
   always_comb begin
      case (bus.alu_ctl)
         3'b000:  bus.alu_out = bus.alu_in1;
         3'b001:  bus.alu_out = bus.alu_in1 + bus.alu_in2;
         3'b010:  bus.alu_out = bus.alu_in1 & bus.alu_in2;
         3'b011:  bus.alu_out = bus.alu_in1 - bus.alu_in2;
         3'b100:  bus.alu_out = bus.alu_in1 << 1;
         3'b101:  bus.alu_out = bus.alu_in1 | bus.alu_in2;
         3'b110:  bus.alu_out = bus.alu_in1 >> 1;
         default: bus.alu_out = '0;
      endcase
      bus.alu_zero = (bus.alu_out == '0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.rsp_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_rsp: got result %0h, required no response", bus.rsp_result);
            end else begin
               cur      = q.pop_front();
               have_cur = 1'b1;
               check("rsp_result", 32'(bus.rsp_result), 32'(cur.res));
               check("rsp_zero", 32'(bus.rsp_zero), 32'(cur.zero));
               check("rsp_latency", 32'(cyc - acc_edge), 32'(cur.lat));
            end
         end else if (bus.rsp_valid === 1'b1 && have_cur) begin
            check("hold_result", 32'(bus.rsp_result), 32'(cur.res));
            check("hold_zero", 32'(bus.rsp_zero), 32'(cur.zero));
         end
         if (bus.rsp_valid === 1'b1) check("hold_req_ready", 32'(bus.req_ready), 32'd0);
         if (bus.rsp_valid !== 1'b1) have_cur = 1'b0;
      end
      prev_valid = bus.rsp_valid;
   end

   task automatic issue(input logic [2:0] op, input logic [SIZE:0] a, input logic [SIZE:0] b,
                        input logic [3:0] sh, input logic [SIZE:0] er, input logic ez,
                        input int el, input bit push);
      bit   ok = 1'b0;
      exp_t e;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_shamt = sh;
      if (push) begin
         e.res  = er;
         e.zero = ez;
         e.lat  = el;
         q.push_back(e);
      end
      for (int k = 0; k < 50; k++) begin
         if (bus.req_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_checks++;
         n_err++;
         $display("FAIL accept_timeout: req_ready %b, required 1", bus.req_ready);
      end
      @(posedge clk);
      #1;
      // Request lines change right after acceptance; the result must not follow.
      bus.req_valid = 1'b0;
      bus.req_op    = 3'($urandom);
      bus.req_a     = 11'($urandom);
      bus.req_b     = 11'($urandom);
      bus.req_shamt = 4'($urandom);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (q.size() == 0 && bus.req_ready === 1'b1 && bus.rsp_valid === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_err++;
         $display("FAIL idle_timeout: pending %0d, required 0", q.size());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = 3'b000;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_shamt = 4'd0;
      bus.rsp_ready = 1'b1;
      repeat (3) @(negedge clk);

      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
      check("rst_rsp_zero", 32'(bus.rsp_zero), 32'd0);
      check("rst_alu_ctl", 32'(bus.alu_ctl), 32'd7);
      check("rst_alu_in1", 32'(bus.alu_in1), 32'd0);
      check("rst_alu_in2", 32'(bus.alu_in2), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(bus.req_ready), 32'd1);

      issue(3'b001, 11'h005, 11'h003, 4'd0, 11'h008, 1'b0, 1, 1'b1); wait_idle();
      issue(3'b011, 11'h1A4, 11'h1A4, 4'd0, 11'h000, 1'b1, 1, 1'b1); wait_idle();
      issue(3'b010, 11'h5A5, 11'h3C3, 4'd0, 11'h181, 1'b0, 1, 1'b1); wait_idle();
      issue(3'b101, 11'h500, 11'h00F, 4'd0, 11'h50F, 1'b0, 1, 1'b1); wait_idle();
      issue(3'b000, 11'h123, 11'h456, 4'd0, 11'h123, 1'b0, 1, 1'b1); wait_idle();
      issue(3'b111, 11'h055, 11'h0AA, 4'd0, 11'h000, 1'b1, 1, 1'b1); wait_idle();
      issue(3'b001, 11'h7FF, 11'h001, 4'd0, 11'h000, 1'b1, 1, 1'b1); wait_idle();

`ifdef ALU_SEQ_MULTISHIFT_EN
      issue(3'b100, 11'h001, 11'h000, 4'd4, 11'h010, 1'b0, 4, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("shl_alu_in1", 32'(bus.alu_in1), 32'd1 << i);
         check("shl_alu_ctl", 32'(bus.alu_ctl), 32'd4);
      end
      wait_idle();
      issue(3'b110, 11'h7FF, 11'h000, 4'd12, 11'h000, 1'b1, 12, 1'b1); wait_idle();
      issue(3'b100, 11'h2AB, 11'h000, 4'd0,  11'h2AB, 1'b0, 1,  1'b1); wait_idle();
      issue(3'b110, 11'h400, 11'h000, 4'd10, 11'h001, 1'b0, 10, 1'b1); wait_idle();
`else
      issue(3'b100, 11'h001, 11'h000, 4'd4, 11'h002, 1'b0, 1, 1'b1);
      @(negedge clk);
      check("shl_alu_in1", 32'(bus.alu_in1), 32'd1);
      check("shl_alu_ctl", 32'(bus.alu_ctl), 32'd4);
      wait_idle();
      issue(3'b110, 11'h7FF, 11'h000, 4'd12, 11'h3FF, 1'b0, 1, 1'b1); wait_idle();
      issue(3'b100, 11'h2AB, 11'h000, 4'd0,  11'h556, 1'b0, 1, 1'b1); wait_idle();
      issue(3'b110, 11'h400, 11'h000, 4'd10, 11'h200, 1'b0, 1, 1'b1); wait_idle();
`endif

      // Back-pressure on the response channel.
      bus.rsp_ready = 1'b0;
      issue(3'b001, 11'h100, 11'h023, 4'd0, 11'h123, 1'b0, 1, 1'b1);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check("stall_busy", 32'(bus.busy), 32'd1);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("post_hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("post_hs_req_ready", 32'(bus.req_ready), 32'd1);
      issue(3'b001, 11'h001, 11'h001, 4'd0, 11'h002, 1'b0, 1, 1'b1); wait_idle();

      // Reset in the middle of an operation abandons it.
`ifdef ALU_SEQ_MULTISHIFT_EN
      bus.rsp_ready = 1'b1;
      issue(3'b100, 11'h003, 11'h000, 4'd6, 11'h000, 1'b0, 0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("shift2_alu_in1", 32'(bus.alu_in1), 32'h6);
      rst_n = 1'b0;
`else
      mon_en        = 1'b0;
      bus.rsp_ready = 1'b0;
      issue(3'b100, 11'h003, 11'h000, 4'd6, 11'h000, 1'b0, 0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("hold_before_rst", 32'(bus.rsp_valid), 32'd1);
      rst_n = 1'b0;
`endif
      @(negedge clk);
      check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
      check("midrst_rsp_result", 32'(bus.rsp_result), 32'd0);
      check("midrst_rsp_zero", 32'(bus.rsp_zero), 32'd0);
      rst_n         = 1'b1;
      bus.rsp_ready = 1'b1;
      mon_en        = 1'b1;
      repeat (15) @(negedge clk);
      check("no_rsp_after_rst", 32'(bus.rsp_valid), 32'd0);

      issue(3'b001, 11'h3FF, 11'h001, 4'd0, 11'h400, 1'b0, 1, 1'b1); wait_idle();
      check("queue_empty", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter SIZE, default 10; data paths SHALL be SIZE+1 bits wide, [SIZE:0].
REQ-002 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 req_valid  in  1  request present; req_ready  out  1  sequencer can accept.
REQ-005 req_op  in  3  ALU op code: 000 pass, 001 add, 010 and, 011 sub, 100 shl1, 101 or, 110 shr1, 111 branch/null.
REQ-006 req_a, req_b  in  SIZE+1  operands; req_shamt  in  4  shift count for ops 100/110.
REQ-007 alu_ctl  out  3, alu_in1/alu_in2  out  SIZE+1: drive the external ALU.
REQ-008 alu_out  in  SIZE+1, alu_zero  in  1: combinational ALU result, same cycle.
REQ-009 rsp_valid  out  1, rsp_ready  in  1, rsp_result  out  SIZE+1, rsp_zero  out  1: result channel.
REQ-010 busy  out  1  high in any state other than IDLE.

Function
REQ-011 States SHALL be IDLE, EXEC, SHIFT, HOLD; req_ready SHALL equal (state==IDLE).
REQ-012 Request SHALL be accepted on an edge with req_valid && req_ready; op, a, b, shamt captured into internal registers.
REQ-013 IDLE SHALL drive alu_ctl=111, alu_in1=0, alu_in2=0.
REQ-014 Non-shift op: IDLE->EXEC on accept; EXEC drives alu_ctl=op, alu_in1=a, alu_in2=b for exactly one cycle.
REQ-015 EXEC end edge SHALL register alu_out->rsp_result, alu_zero->rsp_zero, go HOLD; rsp_valid high from that edge (latency 1 cycle after accept).
REQ-016 Shift op, shamt=0: SHALL behave as non-shift op with alu_ctl=000 (result = a).
REQ-017 Shift op, shamt=n>0: IDLE->SHIFT; n consecutive SHIFT cycles, first drives alu_in1=a, each later cycle drives alu_in1=previous alu_out (internal accumulator); alu_in2=0.
REQ-018 Down-counter SHALL load n at accept, decrement each SHIFT cycle; at count 1, result/zero captured and state->HOLD (latency n cycles).
REQ-019 Shift counts >= SIZE+1 SHALL run all n passes, yielding 0 with rsp_zero=1.
REQ-020 HOLD: rsp_valid, rsp_result, rsp_zero stable until rsp_ready; on rsp_valid && rsp_ready edge -> IDLE, rsp_valid=0.
REQ-021 No new request SHALL be accepted in the cycle a response completes; next accept earliest one edge later.
REQ-022 Op 111 SHALL complete through EXEC with rsp_result=0, rsp_zero=1.
REQ-023 Request inputs SHALL be ignored outside IDLE; changes after accept SHALL not affect the result.

Reset
REQ-024 rst_n low at an edge SHALL force IDLE, rsp_valid=0, rsp_result=0, rsp_zero=0, busy=0, counter=0, accumulator=0, regardless of state.
REQ-025 Reset mid-SHIFT or mid-HOLD SHALL abandon the operation; no response SHALL be issued for it.
REQ-026 req_ready SHALL be 1 on the first edge after rst_n returns high.

Configuration
REQ-027 Macro ALU_SEQ_MULTISHIFT_EN defined: multi-pass shifting per REQ-017..019 and SHIFT state present.
REQ-028 Macro undefined: SHIFT state and counter SHALL be omitted, req_shamt ignored, ops 100/110 SHALL execute as one EXEC pass (shift by 1).

Verification
REQ-029 SIZE=10, op 001, a=0x005, b=0x003, rsp_ready=1 -> rsp_valid one cycle after accept, rsp_result=0x008, rsp_zero=0.
REQ-030 Op 011, a=b=0x1A4 -> rsp_result=0x000, rsp_zero=1.
REQ-031 MULTISHIFT_EN, op 100, a=0x001, shamt=4 -> four SHIFT cycles with alu_in1 1,2,4,8; rsp_result=0x010.
REQ-032 MULTISHIFT_EN, op 110, a=0x7FF, shamt=12 -> rsp_result=0x000, rsp_zero=1 after 12 cycles; macro off, shamt=12 -> rsp_result=0x3FF after 1 cycle.
REQ-033 rsp_ready held 0 for 5 cycles -> rsp_valid/result stable, req_ready=0 throughout; then handshake -> IDLE, next accept one edge later.
REQ-034 rst_n low during 2nd SHIFT cycle of shamt=6 -> IDLE next edge, rsp_valid never asserts for that request.
